fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-side master for the single-clock flex FIFO (sdpram plus fifo ctrl).
- Drives the FIFO read port (`rd_en`, `rd_oce`) and consumes `rd_data`/`rd_empty`, hiding the fixed RAM read latency.
- Presents a valid/ready stream to the downstream consumer, e.g. the conv line feeder.
- Has an internal skid buffer, in-flight read tracking and a flush state machine.

Parameters:
- DATA_WIDTH, 32, FIFO read data width; equals the FIFO's c_RD_DATA_WIDTH.
- RD_LATENCY, 1, cycles from `fifo_rd_en` high to valid `fifo_rd_data`. Legal 1 (FIFO c_OUTPUT_REG=0) or 2 (c_OUTPUT_REG=1, `oce` free-running).
- BUF_DEPTH, 4, skid buffer entries. Legal range RD_LATENCY+2 to 8; RD_LATENCY+2 gives 1 beat/cycle.
- BURST_LEN, 64, beats per frame; used only with FIFO_RD_FRAME_EN. Legal 1 to 65535.

Ports:
- rd_clk  in  1  Single clock, shared with the FIFO read side.
- rd_rst_n  in  1  Asynchronous, active-low reset.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_rd_empty  in  1  FIFO empty flag, registered in the FIFO.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_oce  out  1  FIFO output register enable.
- m_data  out  DATA_WIDTH  Stream data.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready.
- m_last  out  1  Frame last beat; exists only with FIFO_RD_FRAME_EN.
- flush  in  1  Level request to discard all buffered and FIFO content.
- flush_done  out  1  One-cycle pulse when the flush is complete.

Behaviour:
- Reset (rd_rst_n=0, async assert, sync release): all of the following are 0 — `fifo_rd_en`, `fifo_rd_oce`, `m_valid`, `m_data`, `m_last`, `flush_done`, buffer occupancy `occ`, `inflight`, beat count; state = RUN.
- `fifo_rd_oce` = 1 from the first cycle after reset release.
- Read issue (RUN): `fifo_rd_en` = !fifo_rd_empty && (occ + inflight < BUF_DEPTH).
  - `occ` and `inflight` are registered; there is no combinational path from `m_ready` to `fifo_rd_en`.
- `inflight`: an RD_LATENCY-stage shift register of issue bits.
  - The tail bit writes `fifo_rd_data` into the buffer tail in the same cycle it arrives.
  - Count width is clog2(BUF_DEPTH+1).
- Buffer: circular, pointers wrap modulo BUF_DEPTH, FWFT order.
  - `m_valid` = (occ != 0); `m_data` = head entry, driven from the registered head.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle: occ unchanged, both pointers advance.
- Overflow is impossible by the issue rule. An assertion fires if a push arrives with occ == BUF_DEPTH and no pop.
- Empty FIFO: no read is issued. `fifo_rd_empty` updates on the same edge as the read pointer, so back-to-back issue is legal.
- Stream rules:
  - `m_data` and `m_last` stay stable while m_valid && !m_ready.
  - `m_valid` never drops without a handshake, except when entering FLUSH.
- Latency: first word written to an empty FIFO reaches `m_valid` RD_LATENCY+1 cycles after `fifo_rd_empty` falls.
- State machine:
  - RUN → FLUSH when flush=1.
    - At the entry edge: occ and pointers clear to 0, `m_valid`=0.
    - In-flight returns arriving later are discarded.
  - FLUSH:
    - `fifo_rd_en` = !fifo_rd_empty with no buffer limit; returned data is dropped.
    - Beat count clears.
  - FLUSH → RUN when fifo_rd_empty && inflight==0 && flush==0. `flush_done` pulses 1 on that transition edge.
  - If flush is still high when the drain completes, the block stays in FLUSH (keeps discarding) and does not pulse.
- Mid-operation reset: all state is lost immediately; no FIFO read is issued while rd_rst_n=0.

Optional Feature:
- Macro FIFO_RD_FRAME_EN.
- Defined:
  - 16-bit beat counter increments on each handshake.
  - `m_last` = 1 on the handshake beat where count == BURST_LEN-1; the counter then wraps to 0.
  - `m_last` is registered with the buffer entry's position; the count is cleared on flush and reset.
- Undefined: no counter and no `m_last` port; the stream is unframed.

Decomposition:
- Package fifo_rd_pkg holds:
  - state enum {RUN, FLUSH};
  - function clog2;
  - constants for the legal RD_LATENCY range and the BUF_DEPTH minimum.
- One natural sub-module, fifo_rd_skid_buf: circular BUF_DEPTH x DATA_WIDTH buffer with push/pop/clear and occ output.
- The top level holds issue logic, the latency shift register, the FSM and the frame counter.

Test Plan:
- Streaming: RD_LATENCY=1, BUF_DEPTH=3, preload 16 words 0..15, m_ready=1 → m_valid continuous for 16 cycles, m_data 0..15 in order, `fifo_rd_en` low after the 16th issue.
- Backpressure: RD_LATENCY=2, BUF_DEPTH=4, 32 words, m_ready toggling 1/0 → no loss or duplication; occ+inflight never exceeds 4; data held stable during stalls.
- Empty and first word: write one word 0xA5A5_0001 into an empty FIFO → `m_valid` rises exactly RD_LATENCY+1 cycles after `fifo_rd_empty` falls; no read issued while empty.
- Flush: 10 words, m_ready=0, pulse flush for 1 cycle → `m_valid`=0 next cycle, FIFO drained to empty, `flush_done` pulses once; a subsequent write of 0x55 appears as the first post-flush beat.
- Frame (FIFO_RD_FRAME_EN, BURST_LEN=4): 12 words → `m_last` on beats 3, 7, 11 only; flush mid-frame restarts the count at 0.
- Reset: assert rd_rst_n low mid-burst with inflight>0 → all outputs 0 asynchronously; after release, the first beat equals the FIFO's next word with no stale buffer data.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the flex FIFO read-side stream master.
// Used by fifo_rd_stream and fifo_rd_skid_buf.
package fifo_rd_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rd_state_e;

    localparam int RD_LATENCY_MIN   = 1;
    localparam int RD_LATENCY_MAX   = 2;
    // Skid buffer must cover the read latency plus one beat in and one out.
    localparam int BUF_DEPTH_MARGIN = 2;
    localparam int BUF_DEPTH_MAX    = 8;
    localparam int BURST_LEN_MAX    = 65535;
    localparam int BEAT_W           = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular first-word-fall-through buffer holding FIFO read returns.
// Supports push, pop and a synchronous clear of all occupancy state.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  BUF_DEPTH  = 4,
    localparam int PTR_W      = clog2(BUF_DEPTH),
    localparam int CNT_W      = clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0]      occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
            else if (pop_i && !push_i) occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign occ_o       = occ_q;

    // The issue rule reserves space for every read, so a push into a full buffer is a bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !pop_i && !clear_i && occ_q == CNT_W'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for the single-clock flex FIFO: hides RAM read latency behind a
// valid/ready stream with flush support. FIFO_RD_FRAME_EN adds m_last framing.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int BURST_LEN  = 64
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_oce,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef FIFO_RD_FRAME_EN
    output logic                  m_last,
`endif
    input  logic                  flush,
    output logic                  flush_done
);

    // state    | meaning
    // ST_RUN   | issue reads while buffer space is reserved, stream returns out
    // ST_FLUSH | drain FIFO without limit, drop every return, wait for flush low

    localparam int CNT_W = clog2(BUF_DEPTH + 1);

    rd_state_e              state_q, state_d;
    logic                   oce_q;
    logic [RD_LATENCY-1:0]  lat_q, lat_d;
    logic                   flush_done_q, flush_done_d;
    logic [CNT_W-1:0]       occ, inflight;
    logic [CNT_W:0]         reserved;
    logic                   issue, push, pop, clear;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(lat_q[i]);
    end

    assign reserved = {1'b0, occ} + {1'b0, inflight};

    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        clear        = 1'b0;
        flush_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue = oce_q && !fifo_rd_empty && (reserved < (CNT_W + 1)'(BUF_DEPTH));
                if (flush) begin
                    state_d = ST_FLUSH;
                    clear   = 1'b1;
                end
            end
            ST_FLUSH: begin
                issue = oce_q && !fifo_rd_empty;
                if (fifo_rd_empty && inflight == '0 && !flush) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Oldest issue bit marks the cycle its data is on fifo_rd_data.
    always_comb begin
        lat_d    = lat_q << 1;
        lat_d[0] = issue;
    end

    assign push = lat_q[RD_LATENCY-1] && (state_q == ST_RUN);
    assign pop  = m_valid && m_ready;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= ST_RUN;
            oce_q        <= 1'b0;
            lat_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            oce_q        <= 1'b1;
            lat_q        <= lat_d;
            flush_done_q <= flush_done_d;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid_buf (
        .clk_i       (rd_clk),
        .rst_n_i     (rd_rst_n),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop),
        .head_data_o (m_data),
        .occ_o       (occ)
    );

    assign fifo_rd_en  = issue;
    assign fifo_rd_oce = oce_q;
    assign m_valid     = (occ != '0);
    assign flush_done  = flush_done_q;

`ifdef FIFO_RD_FRAME_EN
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clear || state_q == ST_FLUSH) beat_d = '0;
        else if (pop)                     beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) beat_q <= '0;
        else           beat_q <= beat_d;
    end

    assign m_last = m_valid && (beat_q == BEAT_LAST);
`endif

    a_legal_params: assert property (@(posedge rd_clk)
        RD_LATENCY >= RD_LATENCY_MIN && RD_LATENCY <= RD_LATENCY_MAX &&
        BUF_DEPTH >= RD_LATENCY + BUF_DEPTH_MARGIN && BUF_DEPTH <= BUF_DEPTH_MAX &&
        BURST_LEN >= 1 && BURST_LEN <= BURST_LEN_MAX);

endmodule
